// File: rtl/uart_tx_arb.sv
// Round-robin arbiter in front of a UART byte transmitter with no busy output.
// Times each 10-bit frame (plus optional idle gap) itself before granting the next byte.
module uart_tx_arb #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000,
    parameter int GAP_CYC  = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] tx_data,
    output logic       tx_flag,
    output logic       busy,
    output logic       last_b
);
    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int          FRAME_CYC    = 10 * BAUD_CNT_MAX + 2;
    localparam logic [19:0] FRAME_LAST   = 20'(FRAME_CYC - 1);
    localparam logic [19:0] GAP_LAST     = 20'(GAP_CYC - 1);
    localparam bit          HAS_GAP      = (GAP_CYC > 0);

    // state | meaning
    // IDLE  | waiting for a valid byte, winner's ready asserted
    // SEND  | one-cycle tx_flag pulse to the transmitter
    // FRAME | timing the 10-bit frame on the serial line
    // GAP   | extra idle cycles after the frame
    typedef enum logic [1:0] {IDLE, SEND, FRAME, GAP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic        grant_a;
    logic        grant_b;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_ready || b_ready) state_nxt = SEND;
            SEND:    state_nxt = FRAME;
            FRAME:   if (cnt == FRAME_LAST) state_nxt = HAS_GAP ? GAP : IDLE;
            GAP:     if (cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A wins unless B is also waiting and A had the previous grant.
    always_comb begin
        grant_a = a_valid && (!b_valid || last_b);
        grant_b = b_valid && !grant_a;
        a_ready = (state == IDLE) && grant_a;
        b_ready = (state == IDLE) && grant_b;
        tx_flag = (state == SEND);
        busy    = (state != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                FRAME:   cnt <= (cnt == FRAME_LAST) ? 20'd0 : cnt + 20'd1;
                GAP:     cnt <= cnt + 20'd1;
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tx_data <= '0;
            last_b  <= 1'b1;
        end else if (a_ready) begin
            tx_data <= a_data;
            last_b  <= 1'b0;
        end else if (b_ready) begin
            tx_data <= b_data;
            last_b  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: arbitration table, frame timing, hold-off, mid-frame reset and gap.
// Expected bytes go into a queue when driven and are popped on each tx_flag pulse.
module tb_uart_tx_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_data, b_data, tx_data;
    logic       a_valid, b_valid, a_ready, b_ready, tx_flag, busy, last_b;

    logic [7:0] g_a_data, g_b_data, g_tx_data;
    logic       g_a_valid, g_b_valid, g_a_ready, g_b_ready, g_tx_flag, g_busy, g_last_b;

    uart_tx_arb #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .GAP_CYC(0)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .tx_data(tx_data), .tx_flag(tx_flag), .busy(busy), .last_b(last_b)
    );

    uart_tx_arb #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .GAP_CYC(20)) dut_g (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .a_data(g_a_data), .a_valid(g_a_valid), .a_ready(g_a_ready),
        .b_data(g_b_data), .b_valid(g_b_valid), .b_ready(g_b_ready),
        .tx_data(g_tx_data), .tx_flag(g_tx_flag), .busy(g_busy), .last_b(g_last_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] g_exp_q[$];
    int         flag_q[$];
    int         g_flag_q[$];

    always @(negedge clk) begin
        if (tx_flag === 1'b1) begin
            flag_q.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_flag", 1, 0);
            else chk("tx_data_at_flag", int'(tx_data), int'(exp_q.pop_front()));
        end
        if (g_tx_flag === 1'b1) begin
            g_flag_q.push_back(cyc);
            if (g_exp_q.size() == 0) chk("gap_unexpected_flag", 1, 0);
            else chk("gap_tx_data_at_flag", int'(g_tx_data), int'(g_exp_q.pop_front()));
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Present a byte and hold valid until accepted; returns the accept cycle.
    task automatic send(input bit sel, input logic [7:0] d, output int acc);
        acc = -1;
        if (sel) begin b_data = d; b_valid = 1'b1; end
        else     begin a_data = d; a_valid = 1'b1; end
        for (int i = 0; i < 400; i++) begin
            #1;
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                acc = cyc;
                @(negedge clk);
                if (sel) b_valid = 1'b0; else a_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk(sel ? "b_accept_timeout" : "a_accept_timeout", 0, 1);
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    typedef struct {
        bit lb;
        bit av;
        bit bv;
        bit ar;
        bit br;
    } vec_t;
    vec_t tbl[8];

    task automatic apply_tbl(input bit lb);
        chk("tbl_last_b_pre", int'(last_b), int'(lb));
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].lb == lb) begin
                @(negedge clk);
                a_valid = tbl[i].av;
                b_valid = tbl[i].bv;
                #1;
                chk($sformatf("tbl%0d_a_ready", i), int'(a_ready), int'(tbl[i].ar));
                chk($sformatf("tbl%0d_b_ready", i), int'(b_ready), int'(tbl[i].br));
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expired, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, a1, a2, b1, b2, cb, ae, ab, n0;
        int gacc[3];
        logic [7:0] gbytes[3];

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gbytes[0] = 8'hAA; gbytes[1] = 8'hBB; gbytes[2] = 8'hCC;

        rst_n = 1'b0;
        a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0;
        g_a_data = '0; g_b_data = '0; g_a_valid = 1'b0; g_b_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_flag", int'(tx_flag), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_last_b", int'(last_b), 1);
        rst_n = 1'b1;
        @(negedge clk);

        apply_tbl(1'b1);

        // both sources valid continuously: strict alternation starting with A
        @(negedge clk);
        n0 = flag_q.size();
        exp_q.push_back(8'h11); exp_q.push_back(8'h33);
        exp_q.push_back(8'h22); exp_q.push_back(8'h44);
        fork
            begin send(1'b0, 8'h11, a1); send(1'b0, 8'h22, a2); end
            begin send(1'b1, 8'h33, b1); send(1'b1, 8'h44, b2); end
        join
        chk("alt_b1_spacing", b1 - a1, 104);
        chk("alt_a2_spacing", a2 - b1, 104);
        chk("alt_b2_spacing", b2 - a2, 104);
        wait_until(b2 + 2);
        chk("alt_flag_count", flag_q.size() - n0, 4);
        if (flag_q.size() >= n0 + 4) begin
            chk("alt_flag_gap1", flag_q[n0+1] - flag_q[n0], 104);
            chk("alt_flag_gap3", flag_q[n0+3] - flag_q[n0+2], 104);
        end
        chk("alt_last_b", int'(last_b), 1);
        wait_until(b2 + 105);

        // single A byte: flag timing and busy fall
        n0 = flag_q.size();
        exp_q.push_back(8'hA5);
        send(1'b0, 8'hA5, c);
        chk("t1_accepted", int'(c >= 0), 1);
        chk("t1_flag_at_t0p1", int'(tx_flag), 1);
        wait_until(c + 2);
        chk("t1_flag_one_cycle", int'(tx_flag), 0);
        wait_until(c + 103);
        chk("t1_busy_t0p103", int'(busy), 1);
        chk("t1_data_held", int'(tx_data), 8'hA5);
        wait_until(c + 104);
        chk("t1_busy_t0p104", int'(busy), 0);
        chk("t1_flag_count", flag_q.size() - n0, 1);
        chk("t1_last_b", int'(last_b), 0);

        apply_tbl(1'b0);

        // B arrives mid-frame of an A byte
        @(negedge clk);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
        send(1'b0, 8'h5A, c);
        wait_until(c + 50);
        fork
            send(1'b1, 8'hC3, cb);
            begin
                wait_until(c + 60);
                chk("t4_b_ready_held_off", int'(b_ready), 0);
                chk("t4_tx_data_held", int'(tx_data), 8'h5A);
                chk("t4_busy", int'(busy), 1);
            end
        join
        chk("t4_b_accept_cycle", cb - c, 104);
        wait_until(cb + 105);

        // a_valid pulse while busy is ignored
        n0 = flag_q.size();
        exp_q.push_back(8'h77);
        send(1'b0, 8'h77, c);
        wait_until(c + 30);
        a_data = 8'h99; a_valid = 1'b1;
        #1;
        chk("t6_a_ready_busy", int'(a_ready), 0);
        @(negedge clk);
        a_valid = 1'b0;
        wait_until(c + 103);
        chk("t6_busy_t0p103", int'(busy), 1);
        wait_until(c + 104);
        chk("t6_busy_t0p104", int'(busy), 0);
        wait_until(c + 110);
        chk("t6_flag_count", flag_q.size() - n0, 1);
        chk("t6_tx_data", int'(tx_data), 8'h77);

        // reset at FRAME count 50 with A and B both pending
        n0 = flag_q.size();
        exp_q.push_back(8'h3C);
        send(1'b0, 8'h3C, c);
        exp_q.push_back(8'hE1); exp_q.push_back(8'h4B);
        fork
            send(1'b0, 8'hE1, ae);
            send(1'b1, 8'h4B, ab);
            begin
                wait_until(c + 52);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("t5_busy", int'(busy), 0);
                chk("t5_tx_data", int'(tx_data), 0);
                chk("t5_last_b", int'(last_b), 1);
                chk("t5_tx_flag", int'(tx_flag), 0);
            end
        join
        chk("t5_a_reaccept", ae - c, 53);
        chk("t5_b_after", ab - c, 157);
        wait_until(ab + 105);
        chk("t5_flag_count", flag_q.size() - n0, 3);

        // gap instance: A streams three bytes
        for (int i = 0; i < 3; i++) g_exp_q.push_back(gbytes[i]);
        for (int i = 0; i < 3; i++) begin
            g_a_data = gbytes[i];
            g_a_valid = 1'b1;
            gacc[i] = -1;
            for (int k = 0; k < 400 && gacc[i] < 0; k++) begin
                #1;
                if (g_a_ready === 1'b1) gacc[i] = cyc;
                @(negedge clk);
            end
            if (gacc[i] < 0) chk("gap_accept_timeout", 0, 1);
        end
        chk("gap_acc_spacing1", gacc[1] - gacc[0], 124);
        chk("gap_acc_spacing2", gacc[2] - gacc[1], 124);
        wait_until(gacc[2] + 110);
        chk("gap_ready_in_gap", int'(g_a_ready), 0);
        chk("gap_busy_in_gap", int'(g_busy), 1);
        g_a_valid = 1'b0;
        wait_until(gacc[2] + 125);
        chk("gap_busy_end", int'(g_busy), 0);
        chk("gap_flag_count", g_flag_q.size(), 3);
        if (g_flag_q.size() >= 3) begin
            chk("gap_flag_spacing1", g_flag_q[1] - g_flag_q[0], 124);
            chk("gap_flag_spacing2", g_flag_q[2] - g_flag_q[1], 124);
        end

        chk("exp_q_drained", exp_q.size(), 0);
        chk("gap_exp_q_drained", g_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
